wb_round_robin_arbiter: RTL and testbench
=========================================

Name: wb_round_robin_arbiter

Overview:
- Shares one pipelined Wishbone target (e.g. debug register bank / LED block) between NUM_CONTROLLERS controllers (debug_buttons and peers).
- Round-robin arbitration. Grant is held for a whole cyc bus cycle.
- Non-granted controllers see stall and no responses.
- Sits between the controller ports and the single target port on the system bus.

Parameters:
- NUM_CONTROLLERS, 2, number of controller ports (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 1024, cycles without a response before abort (WB_ARB_TIMEOUT_EN only).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- c_cyc_i  in  NUM_CONTROLLERS  per-controller cyc.
- c_stb_i  in  NUM_CONTROLLERS  per-controller stb.
- c_we_i  in  NUM_CONTROLLERS  per-controller we.
- c_adr_i  in  NUM_CONTROLLERS*ADDR_WIDTH  packed addresses; controller k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- c_dat_i  in  NUM_CONTROLLERS*DATA_WIDTH  packed write data.
- c_dat_o  out  DATA_WIDTH  read data, broadcast to all controllers.
- c_ack_o  out  NUM_CONTROLLERS  per-controller ack.
- c_err_o  out  NUM_CONTROLLERS  per-controller err.
- c_rty_o  out  NUM_CONTROLLERS  per-controller rty.
- c_stall_o  out  NUM_CONTROLLERS  per-controller stall.
- t_cyc_o  out  1  target cyc.
- t_stb_o  out  1  target stb.
- t_we_o  out  1  target we.
- t_adr_o  out  ADDR_WIDTH  target address.
- t_dat_o  out  DATA_WIDTH  target write data.
- t_dat_i  in  DATA_WIDTH  target read data.
- t_ack_i  in  1  target ack.
- t_err_i  in  1  target err.
- t_rty_i  in  1  target rty.
- t_stall_i  in  1  target stall.
- grant_o  out  NUM_CONTROLLERS  one-hot current owner (debug visibility).

Behaviour:
- Reset (rst_ni low, async):
  - state=IDLE, grant=0, round-robin pointer=0.
  - t_cyc_o/t_stb_o=0; all c_ack/err/rty_o=0; c_stall_o=all 1s; grant_o=0.
  - Reset mid-transaction drops t_cyc_o immediately; outstanding responses are lost.
- States:
  - IDLE:
    - If any c_cyc_i is high at the clock edge, grant the first requester at or after pointer (wrapping modulo NUM_CONTROLLERS).
    - Go to OWNED with grant registered.
    - If no c_cyc_i is high, stay in IDLE.
  - OWNED:
    - t_cyc_o = c_cyc_i[g]; t_stb_o, t_we_o, t_adr_o, t_dat_o = controller g's signals (combinational mux on registered grant).
    - c_stall_o[g] = t_stall_i; c_ack/err/rty_o[g] = t_ack/err/rty_i & c_cyc_i[g].
    - Edge with c_cyc_i[g] low: go to IDLE, grant=0, pointer=g+1 (wrap to 0 after NUM_CONTROLLERS-1).
- Latency:
  - Request sampled at edge n; grant_o and t_cyc_o are high after edge n.
  - Target sees the first stb in the cycle after the request, or later if the controller is stalled.
- Re-arbitration:
  - Exactly one dead IDLE cycle between owners; no back-to-back handover.
- Non-owners: c_stall_o=1, ack/err/rty=0, regardless of target activity.
- Responses arriving after the owner drops cyc are discarded and not routed to anyone.
- Simultaneous requests in IDLE are resolved by the pointer only; a lower index has no fixed priority.
- A controller holding cyc indefinitely keeps the bus; fairness applies only between bus cycles.
- c_dat_o = t_dat_i unconditionally.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - Add an ABORT state and a counter of width $clog2(TIMEOUT_CYCLES+1).
  - The counter clears on entering OWNED and on any t_ack_i/t_err_i/t_rty_i.
  - The counter increments each OWNED cycle while c_cyc_i[g] is high.
  - When the counter reaches TIMEOUT_CYCLES:
    - c_err_o[g] pulses for 1 cycle and the state goes to ABORT.
    - In ABORT, t_cyc_o=0, c_stall_o[g]=1, and target responses are discarded.
    - ABORT goes to IDLE (pointer advanced) when c_cyc_i[g] drops.
  - The counter never exceeds TIMEOUT_CYCLES.
- Disabled: no counter or ABORT state; a bus cycle waits forever for a response.

Test Plan:
- Single request: c_cyc_i=01, write adr 0x10, dat 0xA5, target ack 2 cycles after stb.
  - Required: grant_o=01 one cycle after request; t_adr_o=0x10, t_dat_o=0xA5; c_ack_o=01 for exactly 1 cycle.
- Contention from reset: c_cyc_i=11 at the same edge.
  - Required: controller 0 granted first; after it drops cyc, 1 IDLE cycle, then grant_o=10; the next contention grants controller 0 again.
- Stall passthrough: target holds t_stall_i=1 for 3 cycles while owner 1 asserts stb.
  - Required: c_stall_o=11 for those 3 cycles; t_stb_o stays high; non-owner stall stays 1 throughout.
- Late response: owner drops cyc, target asserts t_ack_i on the next cycle.
  - Required: c_ack_o=00; state is IDLE.
- Reset mid-cycle: rst_ni low during OWNED with t_stb_o=1.
  - Required: t_cyc_o=0 and grant_o=0 in the same cycle (async), without waiting for a clock edge; pointer=0 after release.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: owner 0 sends stb and the target never responds.
  - Required: c_err_o[0] pulses 8 cycles after the grant; t_cyc_o drops; the bus passes to controller 1 after controller 0 drops cyc.

Source files
------------

// File: rtl/wb_round_robin_arbiter.sv
// Round-robin share of one pipelined Wishbone target; the grant is held for a whole cyc.
// Latency: grant one cycle after cyc is sampled, owner<->target path combinational.
// Backpressure: owner sees t_stall_i, non-owners stalled. Optional WB_ARB_TIMEOUT_EN aborts on silence.
module wb_round_robin_arbiter #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_CONTROLLERS-1:0]            c_cyc_i,
  input  logic [NUM_CONTROLLERS-1:0]            c_stb_i,
  input  logic [NUM_CONTROLLERS-1:0]            c_we_i,
  input  logic [NUM_CONTROLLERS*ADDR_WIDTH-1:0] c_adr_i,
  input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0] c_dat_i,
  output logic [DATA_WIDTH-1:0]                 c_dat_o,
  output logic [NUM_CONTROLLERS-1:0]            c_ack_o,
  output logic [NUM_CONTROLLERS-1:0]            c_err_o,
  output logic [NUM_CONTROLLERS-1:0]            c_rty_o,
  output logic [NUM_CONTROLLERS-1:0]            c_stall_o,
  output logic                                  t_cyc_o,
  output logic                                  t_stb_o,
  output logic                                  t_we_o,
  output logic [ADDR_WIDTH-1:0]                 t_adr_o,
  output logic [DATA_WIDTH-1:0]                 t_dat_o,
  input  logic [DATA_WIDTH-1:0]                 t_dat_i,
  input  logic                                  t_ack_i,
  input  logic                                  t_err_i,
  input  logic                                  t_rty_i,
  input  logic                                  t_stall_i,
  output logic [NUM_CONTROLLERS-1:0]            grant_o
);

  localparam int PW = $clog2(NUM_CONTROLLERS);

  if (NUM_CONTROLLERS < 2 || NUM_CONTROLLERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("wb_round_robin_arbiter: unsupported parameter value");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_e;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
`else
  typedef enum logic [1:0] {IDLE, OWNED} state_e;
`endif

  state_e                     state_q;
  logic [NUM_CONTROLLERS-1:0] grant_q;
  logic [PW-1:0]              own_q;
  logic [PW-1:0]              ptr_q;
  logic [PW-1:0]              ptr_next;
  logic [PW-1:0]              cand;
  logic [PW-1:0]              pick_idx;
  logic                       pick_vld;
  logic                       owned;
  logic                       own_cyc;

  logic [ADDR_WIDTH-1:0] adr_a [NUM_CONTROLLERS];
  logic [DATA_WIDTH-1:0] dat_a [NUM_CONTROLLERS];

  for (genvar i = 0; i < NUM_CONTROLLERS; i++) begin : g_unpack
    assign adr_a[i] = c_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[i] = c_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owned    = (state_q == OWNED);
  assign own_cyc  = c_cyc_i[own_q];
  assign ptr_next = (own_q == PW'(NUM_CONTROLLERS - 1)) ? '0 : own_q + PW'(1);
  assign grant_o  = grant_q;
  assign c_dat_o  = t_dat_i;

  // First requester at or after the pointer, wrapping; no fixed index priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      if (int'(ptr_q) + i >= NUM_CONTROLLERS) cand = PW'(int'(ptr_q) + i - NUM_CONTROLLERS);
      else                                    cand = PW'(int'(ptr_q) + i);
      if (!pick_vld && c_cyc_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign tmo_hit = owned && (tmo_q == TMO_MAX);
`endif

  always_comb begin
    t_cyc_o   = owned & own_cyc;
    t_stb_o   = owned & c_stb_i[own_q];
    t_we_o    = owned & c_we_i[own_q];
    t_adr_o   = owned ? adr_a[own_q] : '0;
    t_dat_o   = owned ? dat_a[own_q] : '0;
    c_stall_o = '1;
    c_ack_o   = '0;
    c_err_o   = '0;
    c_rty_o   = '0;
    if (owned) begin
      c_stall_o[own_q] = t_stall_i;
      c_ack_o[own_q]   = t_ack_i & own_cyc;
      c_err_o[own_q]   = t_err_i & own_cyc;
      c_rty_o[own_q]   = t_rty_i & own_cyc;
`ifdef WB_ARB_TIMEOUT_EN
      if (tmo_hit) c_err_o[own_q] = own_cyc;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= OWNED;
            own_q   <= pick_idx;
            grant_q <= NUM_CONTROLLERS'(1) << pick_idx;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_next;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (tmo_hit)                       state_q <= ABORT;
          else if (t_ack_i || t_err_i || t_rty_i) tmo_q   <= '0;
          else                                    tmo_q   <= tmo_q + TW'(1);
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_next;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_round_robin_arbiter.sv
// Directed bench for wb_round_robin_arbiter with two controllers and TIMEOUT_CYCLES=8.
// Expected values are hand-derived per scenario; each task checks inline.
module tb_wb_round_robin_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  c_cyc, c_stb, c_we;
  logic [63:0] c_adr, c_dat;
  logic [31:0] c_dat_o_w, t_adr, t_dat, t_dat_i;
  logic [1:0]  c_ack, c_err, c_rty, c_stall, grant;
  logic        t_cyc, t_stb, t_we, t_ack, t_err, t_rty, t_stall;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_round_robin_arbiter #(
    .NUM_CONTROLLERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c_cyc_i(c_cyc), .c_stb_i(c_stb), .c_we_i(c_we), .c_adr_i(c_adr), .c_dat_i(c_dat),
    .c_dat_o(c_dat_o_w), .c_ack_o(c_ack), .c_err_o(c_err), .c_rty_o(c_rty), .c_stall_o(c_stall),
    .t_cyc_o(t_cyc), .t_stb_o(t_stb), .t_we_o(t_we), .t_adr_o(t_adr), .t_dat_o(t_dat),
    .t_dat_i(t_dat_i), .t_ack_i(t_ack), .t_err_i(t_err), .t_rty_i(t_rty), .t_stall_i(t_stall),
    .grant_o(grant)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (t_cyc !== 1'b0) begin errors++; $display("FAIL reset_tcyc got %b want 0", t_cyc); end
    checks++; if (t_stb !== 1'b0) begin errors++; $display("FAIL reset_tstb got %b want 0", t_stb); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (c_stall !== 2'b11) begin errors++; $display("FAIL reset_stall got %b want 11", c_stall); end
    checks++; if ({c_ack, c_err, c_rty} !== 6'b0) begin errors++; $display("FAIL reset_resp got %b want 000000", {c_ack, c_err, c_rty}); end
    t_dat_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (c_dat_o_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_datbcast got %h want deadbeef", c_dat_o_w); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    c_cyc = 2'b01; c_stb = 2'b01; c_we = 2'b01;
    c_adr[31:0] = 32'h10; c_dat[31:0] = 32'hA5;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_pregrant got %b want 00", grant); end
    tick;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", grant); end
    checks++; if ({t_cyc, t_stb, t_we} !== 3'b111) begin errors++; $display("FAIL single_ctl got %b want 111", {t_cyc, t_stb, t_we}); end
    checks++; if (t_adr !== 32'h10) begin errors++; $display("FAIL single_adr got %h want 10", t_adr); end
    checks++; if (t_dat !== 32'hA5) begin errors++; $display("FAIL single_dat got %h want a5", t_dat); end
    checks++; if (c_stall !== 2'b10) begin errors++; $display("FAIL single_stall got %b want 10", c_stall); end
    c_stb = 2'b00;
    tick;
    checks++; if (t_stb !== 1'b0) begin errors++; $display("FAIL single_stbdrop got %b want 0", t_stb); end
    checks++; if (c_ack !== 2'b00) begin errors++; $display("FAIL single_noack got %b want 00", c_ack); end
    tick;
    t_ack = 1'b1;
    #1;
    checks++; if (c_ack !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", c_ack); end
    tick;
    t_ack = 1'b0;
    #1;
    checks++; if (c_ack !== 2'b00) begin errors++; $display("FAIL single_ackpulse got %b want 00", c_ack); end
    c_cyc = 2'b00;
    tick;
    checks++; if ({grant, t_cyc} !== 3'b000) begin errors++; $display("FAIL single_release got %b want 000", {grant, t_cyc}); end
  endtask

  task automatic test_pointer;
    c_cyc = 2'b11;
    tick;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL pointer_grant got %b want 10", grant); end
    c_cyc = 2'b00;
    tick;
  endtask

  task automatic test_contention;
    do_reset;
    c_cyc = 2'b11;
    tick;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first got %b want 01", grant); end
    tick;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_hold got %b want 01", grant); end
    c_cyc = 2'b10;
    tick;
    checks++; if ({grant, t_cyc} !== 3'b000) begin errors++; $display("FAIL cont_dead got %b want 000", {grant, t_cyc}); end
    tick;
    checks++; if ({grant, t_cyc} !== 3'b101) begin errors++; $display("FAIL cont_second got %b want 101", {grant, t_cyc}); end
    c_cyc = 2'b00;
    tick;
    c_cyc = 2'b11;
    tick;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_wrap got %b want 01", grant); end
    c_cyc = 2'b00;
    tick;
  endtask

  task automatic test_stall;
    c_cyc = 2'b10; c_stb = 2'b10; c_we = 2'b00;
    c_adr[63:32] = 32'h20; c_dat[63:32] = 32'h5A;
    tick;
    t_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (c_stall !== 2'b11) begin errors++; $display("FAIL stall_pass%0d got %b want 11", i, c_stall); end
      checks++; if (t_stb !== 1'b1 || t_adr !== 32'h20) begin errors++; $display("FAIL stall_stb%0d got %b/%h want 1/20", i, t_stb, t_adr); end
      tick;
    end
    t_stall = 1'b0;
    #1;
    checks++; if (c_stall !== 2'b01) begin errors++; $display("FAIL stall_release got %b want 01", c_stall); end
    checks++; if (t_dat !== 32'h5A || t_we !== 1'b0) begin errors++; $display("FAIL stall_dat got %h/%b want 5a/0", t_dat, t_we); end
    c_stb = 2'b00;
    tick;
    t_ack = 1'b1; t_rty = 1'b1;
    #1;
    checks++; if ({c_ack, c_rty} !== 4'b1010) begin errors++; $display("FAIL stall_resp got %b want 1010", {c_ack, c_rty}); end
    tick;
    t_ack = 1'b0; t_rty = 1'b0;
  endtask

  task automatic test_late_response;
    c_cyc = 2'b00;
    tick;
    t_ack = 1'b1; t_err = 1'b1;
    #1;
    checks++; if ({c_ack, c_err} !== 4'b0000) begin errors++; $display("FAIL late_resp got %b want 0000", {c_ack, c_err}); end
    checks++; if ({grant, t_cyc} !== 3'b000) begin errors++; $display("FAIL late_idle got %b want 000", {grant, t_cyc}); end
    tick;
    t_ack = 1'b0; t_err = 1'b0;
    tick;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL late_stayidle got %b want 00", grant); end
  endtask

  task automatic test_reset_mid;
    c_cyc = 2'b01; c_stb = 2'b01;
    tick;
    c_cyc = 2'b00;
    tick;
    c_cyc = 2'b01;
    tick;
    checks++; if (grant !== 2'b01 || t_stb !== 1'b1) begin errors++; $display("FAIL rmid_owned got %b/%b want 01/1", grant, t_stb); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({t_cyc, t_stb, grant} !== 4'b0000) begin errors++; $display("FAIL rmid_async got %b want 0000", {t_cyc, t_stb, grant}); end
    checks++; if (c_stall !== 2'b11) begin errors++; $display("FAIL rmid_stall got %b want 11", c_stall); end
    c_cyc = 2'b11; c_stb = 2'b00;
    #1;
    rst_n = 1'b1;
    tick;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_ptr got %b want 01", grant); end
    c_cyc = 2'b00;
    tick;
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    c_cyc = 2'b01; c_stb = 2'b01;
    tick;
    c_stb = 2'b00;
    for (int k = 0; k < 8; k++) begin
      checks++; if (c_err !== 2'b00 || t_cyc !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d got %b/%b want 00/1", k, c_err, t_cyc); end
      tick;
    end
    checks++; if (c_err !== 2'b01) begin errors++; $display("FAIL tmo_err got %b want 01", c_err); end
    c_cyc = 2'b11;
    tick;
    checks++; if ({c_err, t_cyc} !== 3'b000) begin errors++; $display("FAIL tmo_abort got %b want 000", {c_err, t_cyc}); end
    checks++; if (c_stall !== 2'b11) begin errors++; $display("FAIL tmo_stall got %b want 11", c_stall); end
    tick;
    checks++; if (t_cyc !== 1'b0 || grant == 2'b10) begin errors++; $display("FAIL tmo_hold got %b/%b want 0/not10", t_cyc, grant); end
    c_cyc = 2'b10;
    tick;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tmo_idle got %b want 00", grant); end
    tick;
    checks++; if ({grant, t_cyc} !== 3'b101) begin errors++; $display("FAIL tmo_handover got %b want 101", {grant, t_cyc}); end
    c_cyc = 2'b00;
    tick;
  endtask
`else
  task automatic test_no_timeout;
    c_cyc = 2'b01; c_stb = 2'b01;
    tick;
    c_stb = 2'b00;
    repeat (12) tick;
    checks++; if ({grant, t_cyc, c_err} !== 5'b01100) begin errors++; $display("FAIL notmo_hold got %b want 01100", {grant, t_cyc, c_err}); end
    c_cyc = 2'b00;
    tick;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    c_cyc = '0; c_stb = '0; c_we = '0; c_adr = '0; c_dat = '0;
    t_dat_i = '0; t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0;
    test_reset;
    test_single;
    test_pointer;
    test_contention;
    test_stall;
    test_late_response;
    test_reset_mid;
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
